// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with 3-sample majority vote per bit,
// optional parity, 1/2 stop bits, break recovery and a one-entry holding reg.
// Ports:
//   clk_i, rst_i           bus clock, synchronous active-high reset
//   baud_tick_i            1-cycle enable at OVERSAMPLE x baud
//   rx_i                   async serial line, idle high
//   rx_data_o, rx_valid_o  holding register out (valid/ready)
//   rx_ready_i             downstream accepts; transfer = valid & ready
//   err_clr_i              clears sticky errors
//   rx_stat_o              {overrun, frame_err, parity_err, busy}
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 baud_tick_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  input  logic                 err_clr_i,
  output logic [3:0]           rx_stat_o
);

  localparam int M  = OVERSAMPLE / 2;
  localparam int TW = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_M0   = TW'(M - 1);
  localparam logic [TW-1:0] T_M1   = TW'(M);
  localparam logic [TW-1:0] T_M2   = TW'(M + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    B_LAST = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  } state_t;

  state_t               state;
  logic                 sync1, rxs;
  logic [TW-1:0]        tick_cnt;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 s0, s1;
  logic                 maj, last_tick;
  logic [DATA_BITS-1:0] shreg;
  logic                 fe_f, pe_f;
  logic                 done, done_fe, done_pe;
  logic [DATA_BITS-1:0] done_data;
  logic                 ovr, fe, pe;

  assign maj       = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign last_tick = (tick_cnt == T_LAST);
  assign rx_stat_o = {ovr, fe, pe, state != IDLE};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_i;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      s0        <= 1'b0;
      s1        <= 1'b0;
      shreg     <= '0;
      fe_f      <= 1'b0;
      pe_f      <= 1'b0;
      done      <= 1'b0;
      done_fe   <= 1'b0;
      done_pe   <= 1'b0;
      done_data <= '0;
    end else begin
      done <= 1'b0;
      if (baud_tick_i) begin
        if (state != IDLE)
          tick_cnt <= last_tick ? '0 : tick_cnt + T_ONE;
        if (tick_cnt == T_M0) s0 <= rxs;
        if (tick_cnt == T_M1) s1 <= rxs;
        unique case (state)
          IDLE: begin
            // detect tick is tick 0 of the start bit
            if (!rxs) begin
              state    <= START;
              tick_cnt <= T_ONE;
              bit_cnt  <= '0;
              stop_cnt <= 1'b0;
              fe_f     <= 1'b0;
              pe_f     <= 1'b0;
            end
          end
          START: begin
            if (tick_cnt == T_M2 && maj) begin
              state    <= IDLE;
              tick_cnt <= '0;
            end else if (last_tick) begin
              state <= DATA;
            end
          end
          DATA: begin
            if (tick_cnt == T_M2)
              shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (last_tick) begin
              if (bit_cnt == B_LAST) begin
                bit_cnt <= '0;
                state   <= (PARITY_EN != 0) ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          PARITY: begin
            if (tick_cnt == T_M2 &&
                maj != ((^shreg) ^ 1'(PARITY_ODD)))
              pe_f <= 1'b1;
            if (last_tick) state <= STOP;
          end
          STOP: begin
            if (tick_cnt == T_M2) begin
              if (STOP_BITS == 2 && !stop_cnt) begin
                if (!maj) fe_f <= 1'b1;
              end else begin
                // complete at mid-bit so the next start edge is not missed
                done      <= 1'b1;
                done_data <= shreg;
                done_fe   <= fe_f | ~maj;
                done_pe   <= pe_f;
                state     <= (fe_f | ~maj) ? WAIT_HIGH : IDLE;
                tick_cnt  <= '0;
              end
            end else if (last_tick) begin
              stop_cnt <= 1'b1;
            end
          end
          WAIT_HIGH: begin
            if (rxs) begin
              state    <= IDLE;
              tick_cnt <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      ovr        <= 1'b0;
      fe         <= 1'b0;
      pe         <= 1'b0;
    end else begin
      if (done) begin
        if (!rx_valid_o || rx_ready_i) begin
          rx_data_o  <= done_data;
          rx_valid_o <= 1'b1;
        end
      end else if (rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
      // a set in the same cycle overrides the clear
      if (err_clr_i) begin
        ovr <= 1'b0;
        fe  <= 1'b0;
        pe  <= 1'b0;
      end
      if (done && rx_valid_o && !rx_ready_i) ovr <= 1'b1;
      if (done && done_fe) fe <= 1'b1;
      if (done && done_pe) pe <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed bench for uart_rx_os, three parameter sets
// (8N1, 8E1, 7N2) driven from one linear stimulus sequence.
module tb_uart_rx_os;

  logic       clk = 1'b0;
  logic       rst, tick, ready, clr;
  logic       rx0, rx1, rx2;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic       v0, v1, v2;
  logic [3:0] st0, st1, st2;

  int checks = 0;
  int errors = 0;
  int nx[3] = '{0, 0, 0};
  int vhi0 = 0;
  logic [8:0] lastd[3] = '{9'h0, 9'h0, 9'h0};

  always #5 clk = ~clk;

  uart_rx_os u0 (
    .clk_i(clk), .rst_i(rst), .baud_tick_i(tick), .rx_i(rx0),
    .rx_data_o(d0), .rx_valid_o(v0), .rx_ready_i(ready),
    .err_clr_i(clr), .rx_stat_o(st0)
  );

  uart_rx_os #(.PARITY_EN(1)) u1 (
    .clk_i(clk), .rst_i(rst), .baud_tick_i(tick), .rx_i(rx1),
    .rx_data_o(d1), .rx_valid_o(v1), .rx_ready_i(ready),
    .err_clr_i(clr), .rx_stat_o(st1)
  );

  uart_rx_os #(.DATA_BITS(7), .STOP_BITS(2)) u2 (
    .clk_i(clk), .rst_i(rst), .baud_tick_i(tick), .rx_i(rx2),
    .rx_data_o(d2), .rx_valid_o(v2), .rx_ready_i(ready),
    .err_clr_i(clr), .rx_stat_o(st2)
  );

  always @(posedge clk) begin
    if (v0) vhi0 <= vhi0 + 1;
    if (v0 && ready) begin
      nx[0] <= nx[0] + 1;
      lastd[0] <= 9'(d0);
    end
    if (v1 && ready) begin
      nx[1] <= nx[1] + 1;
      lastd[1] <= 9'(d1);
    end
    if (v2 && ready) begin
      nx[2] <= nx[2] + 1;
      lastd[2] <= 9'(d2);
    end
  end

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input int i, input logic v);
    case (i)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic bit_t(input int i, input logic v);
    set_rx(i, v);
    idle(16);
  endtask

  // par < 0: no parity bit; s1 = first stop bit, second is always 1
  task automatic send(input int i, input logic [8:0] d,
                      input int nb, input int par,
                      input logic s1, input int ns);
    bit_t(i, 1'b0);
    for (int k = 0; k < nb; k++) bit_t(i, d[k]);
    if (par >= 0) bit_t(i, par[0]);
    bit_t(i, s1);
    if (ns == 2) bit_t(i, 1'b1);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b1; ready = 1'b1; clr = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    idle(4);
    chk("rst_valid0", 16'(v0), 16'h0);
    chk("rst_data0", 16'(d0), 16'h0);
    chk("rst_stat0", 16'(st0), 16'h0);
    chk("rst_stat1", 16'(st1), 16'h0);
    chk("rst_stat2", 16'(st2), 16'h0);
    rst = 1'b0;
    idle(4);

    // 8N1 basic frame
    send(0, 9'h0A5, 8, -1, 1'b1, 1);
    idle(4);
    chk("t1_data", 16'(lastd[0]), 16'h00A5);
    chk("t1_dout", 16'(d0), 16'h00A5);
    chk("t1_nx", 16'(nx[0]), 16'd1);
    chk("t1_vhi", 16'(vhi0), 16'd1);
    chk("t1_valid", 16'(v0), 16'h0);
    chk("t1_stat", 16'(st0), 16'h0);

    // false start: 4 ticks low
    set_rx(0, 1'b0);
    idle(4);
    set_rx(0, 1'b1);
    idle(1);
    chk("t2_busy", 16'(st0[0]), 16'h1);
    idle(20);
    chk("t2_stat", 16'(st0), 16'h0);
    chk("t2_nx", 16'(nx[0]), 16'd1);

    // even parity: good, then bad
    send(1, 9'h003, 8, 0, 1'b1, 1);
    idle(4);
    chk("t3_good_data", 16'(lastd[1]), 16'h0003);
    chk("t3_good_stat", 16'(st1), 16'h0);
    send(1, 9'h007, 8, 0, 1'b1, 1);
    idle(4);
    chk("t3_bad_data", 16'(lastd[1]), 16'h0007);
    chk("t3_bad_stat", 16'(st1), 16'b0010);
    pulse_clr();
    chk("t3_clr", 16'(st1), 16'h0);

    // overrun
    ready = 1'b0;
    send(0, 9'h011, 8, -1, 1'b1, 1);
    idle(4);
    chk("t4_valid", 16'(v0), 16'h1);
    chk("t4_data", 16'(d0), 16'h0011);
    chk("t4_stat", 16'(st0), 16'h0);
    send(0, 9'h022, 8, -1, 1'b1, 1);
    idle(4);
    chk("t4_hold", 16'(d0), 16'h0011);
    chk("t4_ovr", 16'(st0), 16'b1000);
    chk("t4_valid2", 16'(v0), 16'h1);
    pulse_clr();
    chk("t4_clr", 16'(st0), 16'h0);

    // ready only in the completion cycle
    fork
      send(0, 9'h022, 8, -1, 1'b1, 1);
      begin : watch
        int n;
        n = 0;
        while (!st0[0] && n < 60) begin
          @(negedge clk);
          n++;
        end
        chk("t4_busy_rise", 16'(st0[0]), 16'h1);
        n = 0;
        while (st0[0] && n < 250) begin
          @(negedge clk);
          n++;
        end
        chk("t4_busy_fall", 16'(st0[0]), 16'h0);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    idle(2);
    chk("t4_load", 16'(d0), 16'h0022);
    chk("t4_valid3", 16'(v0), 16'h1);
    chk("t4_noovr", 16'(st0), 16'h0);
    chk("t4_xfer_d", 16'(lastd[0]), 16'h0011);
    chk("t4_xfer_n", 16'(nx[0]), 16'd2);
    ready = 1'b1;
    idle(2);
    chk("t4_drain_v", 16'(v0), 16'h0);
    chk("t4_drain_d", 16'(lastd[0]), 16'h0022);
    chk("t4_drain_n", 16'(nx[0]), 16'd3);

    // break: 20 bit times low
    set_rx(0, 1'b0);
    idle(320);
    chk("t5_nx", 16'(nx[0]), 16'd4);
    chk("t5_data", 16'(lastd[0]), 16'h0000);
    chk("t5_stat", 16'(st0), 16'b0101);
    set_rx(0, 1'b1);
    idle(32);
    chk("t5_idle", 16'(st0), 16'b0100);
    pulse_clr();
    send(0, 9'h05A, 8, -1, 1'b1, 1);
    idle(4);
    chk("t5_after_d", 16'(lastd[0]), 16'h005A);
    chk("t5_after_n", 16'(nx[0]), 16'd5);
    chk("t5_after_st", 16'(st0), 16'h0);

    // reset mid-DATA, 8N1
    bit_t(0, 1'b0);
    bit_t(0, 1'b0);
    bit_t(0, 1'b0);
    set_rx(0, 1'b1);
    idle(8);
    pulse_rst();
    chk("t6_valid", 16'(v0), 16'h0);
    chk("t6_data", 16'(d0), 16'h0);
    chk("t6_stat", 16'(st0), 16'h0);
    idle(48);
    chk("t6_nopart", 16'(nx[0]), 16'd5);
    send(0, 9'h03C, 8, -1, 1'b1, 1);
    idle(4);
    chk("t6_rx_d", 16'(lastd[0]), 16'h003C);
    chk("t6_rx_n", 16'(nx[0]), 16'd6);

    // 7N2: good frame, bad first stop, reset mid-DATA
    send(2, 9'h055, 7, -1, 1'b1, 2);
    idle(4);
    chk("t7_data", 16'(lastd[2]), 16'h0055);
    chk("t7_stat", 16'(st2), 16'h0);
    send(2, 9'h02B, 7, -1, 1'b0, 2);
    idle(4);
    chk("t7_fe_data", 16'(lastd[2]), 16'h002B);
    chk("t7_fe_stat", 16'(st2), 16'b0100);
    pulse_clr();
    bit_t(2, 1'b0);
    bit_t(2, 1'b0);
    bit_t(2, 1'b0);
    bit_t(2, 1'b1);
    set_rx(2, 1'b1);
    idle(8);
    pulse_rst();
    chk("t7_rst_v", 16'(v2), 16'h0);
    chk("t7_rst_d", 16'(d2), 16'h0);
    chk("t7_rst_st", 16'(st2), 16'h0);
    idle(48);
    chk("t7_nopart", 16'(nx[2]), 16'd2);
    send(2, 9'h03C, 7, -1, 1'b1, 2);
    idle(4);
    chk("t7_rx_d", 16'(lastd[2]), 16'h003C);
    chk("t7_rx_n", 16'(nx[2]), 16'd3);
    chk("t7_rx_st", 16'(st2), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
